// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command sequencer.
// Covers the FSM encoding, protocol byte defaults and frame geometry.
package uart_cmd_pkg;

    // Frame states are numbered in byte order, so the checksum state equals FRAME_LEN-1.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DHI   = 3'd2,
        ST_DLO   = 3'd3,
        ST_CSUM  = 3'd4,
        ST_WRITE = 3'd5,
        ST_RESP  = 3'd6
    } state_t;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT      = 8'hA5;
    localparam logic [7:0]  ACK_BYTE_DEFAULT       = 8'h06;
    localparam logic [7:0]  NAK_BYTE_DEFAULT       = 8'h15;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 250000;
    localparam int          FRAME_LEN              = 5;
    localparam state_t      LAST_FRAME_STATE       = state_t'(FRAME_LEN - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the receiver's per-byte toggle into a one-cycle strobe.
// The first clock after reset only arms the detector, so a toggle left high never fires.
module uart_byte_strobe (
    input  logic clk,
    input  logic rst,
    input  logic rx_toggle,
    output logic byte_stb
);

    logic toggle_q;
    logic armed;

    // NOTE: non-blocking assignments so both registers sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_q <= 1'b0;
            armed    <= 1'b0;
        end else begin
            toggle_q <= rx_toggle;
            armed    <= 1'b1;
        end
    end

    assign byte_stb = armed & (rx_toggle ^ toggle_q);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses SYNC/ADDR/DHI/DLO/CSUM frames from the UART into register writes,
// answers each checked frame with ACK or NAK and aborts stalled frames.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEFAULT,
    parameter logic [7:0]  NAK_BYTE       = NAK_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        CLOCK,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_toggle,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_busy,
    output logic [7:0]  err_count
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic byte_stb;

    uart_byte_strobe u_byte_strobe (
        .clk       (CLOCK),
        .rst       (reset),
        .rx_toggle (rx_toggle),
        .byte_stb  (byte_stb)
    );

    state_t          state, state_next;
    logic [7:0]      sum, sum_next;
    logic [WD_W-1:0] wd_count, wd_next;
    logic [7:0]      addr_next;
    logic [15:0]     data_next;
    logic            valid_next;
    logic [7:0]      tx_data_next;
    logic            send_next;
    logic [7:0]      err_next;
    logic            wd_active;

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sum       <= '0;
            wd_count  <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_valid  <= 1'b0;
            tx_data   <= '0;
            tx_send   <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            sum       <= sum_next;
            wd_count  <= wd_next;
            wr_addr   <= addr_next;
            wr_data   <= data_next;
            wr_valid  <= valid_next;
            tx_data   <= tx_data_next;
            tx_send   <= send_next;
            err_count <= err_next;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first so no latch is inferred.
        state_next   = state;
        sum_next     = sum;
        wd_next      = wd_count;
        addr_next    = wr_addr;
        data_next    = wr_data;
        valid_next   = wr_valid;
        tx_data_next = tx_data;
        send_next    = 1'b0;
        err_next     = err_count;

        wd_active = (state >= ST_ADDR) && (state <= LAST_FRAME_STATE);
        if (wd_active) begin
            wd_next = byte_stb ? '0 : wd_count + WD_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (byte_stb && rx_data == SYNC_BYTE) begin
                    state_next = ST_ADDR;
                    wd_next    = '0;
                end
            end
            ST_ADDR: begin
                if (byte_stb) begin
                    addr_next  = rx_data;
                    sum_next   = rx_data;
                    state_next = ST_DHI;
                end
            end
            ST_DHI: begin
                if (byte_stb) begin
                    data_next  = {rx_data, wr_data[7:0]};
                    sum_next   = sum + rx_data;
                    state_next = ST_DLO;
                end
            end
            ST_DLO: begin
                if (byte_stb) begin
                    data_next  = {wr_data[15:8], rx_data};
                    sum_next   = sum + rx_data;
                    state_next = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (byte_stb) begin
                    if (rx_data == sum) begin
                        valid_next = 1'b1;
                        state_next = ST_WRITE;
                    end else begin
                        tx_data_next = NAK_BYTE;
                        err_next     = sat_inc(err_count);
                        state_next   = ST_RESP;
                    end
                end
            end
            ST_WRITE: begin
                // Bytes arriving while a command is still in flight are dropped.
                if (byte_stb) begin
                    err_next = sat_inc(err_count);
                end
                if (wr_ready) begin
                    valid_next   = 1'b0;
                    tx_data_next = ACK_BYTE;
                    state_next   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (byte_stb) begin
                    err_next = sat_inc(err_count);
                end
                if (!tx_busy) begin
                    send_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A byte on the final watchdog cycle still counts, so only a silent cycle aborts.
        if (wd_active && !byte_stb && wd_count == WD_LAST) begin
            state_next = ST_IDLE;
            err_next   = sat_inc(err_count);
            wd_next    = '0;
        end
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: directed scenarios plus randomized
// frames scored against a byte-level frame model with expected-write and response queues.
module tb_uart_cmd_sequencer;

    localparam int         T    = 64;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'hA5;
    logic        rx_toggle = 1'b1;
    logic        wr_ready = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic [7:0]  err_count;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  model_err = 8'd0;
    bit          mon_en = 1'b0;
    bit          rand_hs = 1'b0;

    always #5 clk = ~clk;

    uart_cmd_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .CLOCK     (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_toggle (rx_toggle),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .tx_busy   (tx_busy),
        .err_count (err_count)
    );

    // Random handshake pressure for the randomized scenario.
    always begin
        @(negedge clk);
        if (rand_hs) begin
            wr_ready = 1'($urandom_range(0, 1));
            tx_busy  = ($urandom_range(0, 3) == 0);
        end
    end

    // Scoreboard: every accepted write and every sent response must match the model queues.
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic        prev_busy = 1'b0;
    logic        prev_send = 1'b0;
    logic [23:0] prev_wr = '0;
    always begin
        logic [23:0] e_wr;
        logic [7:0]  e_tx;
        @(negedge clk);
        #2;
        if (mon_en) begin
            if (wr_valid && wr_ready) begin
                vectors++;
                if (exp_wr.size() == 0) begin
                    miscompares++;
                    $display("FAIL write_unexpected: got addr=%h data=%h, required no write", wr_addr, wr_data);
                end else begin
                    e_wr = exp_wr.pop_front();
                    if ({wr_addr, wr_data} !== e_wr)
                        begin
                            miscompares++;
                            $display("FAIL write_content: got %h, required %h", {wr_addr, wr_data}, e_wr);
                        end
                end
            end
            if (wr_valid && prev_valid && !prev_hs) begin
                vectors++;
                if ({wr_addr, wr_data} !== prev_wr) begin
                    miscompares++;
                    $display("FAIL write_hold: got %h, required stable %h", {wr_addr, wr_data}, prev_wr);
                end
            end
            if (tx_send) begin
                vectors++;
                if (exp_tx.size() == 0) begin
                    miscompares++;
                    $display("FAIL tx_unexpected: got tx_data=%h, required no send", tx_data);
                end else begin
                    e_tx = exp_tx.pop_front();
                    if (tx_data !== e_tx) begin
                        miscompares++;
                        $display("FAIL tx_content: got %h, required %h", tx_data, e_tx);
                    end
                end
                vectors++;
                if (prev_busy !== 1'b0 || prev_send !== 1'b0) begin
                    miscompares++;
                    $display("FAIL tx_pulse: got busy_before=%b send_before=%b, required 0 0", prev_busy, prev_send);
                end
            end
        end
        prev_valid = wr_valid;
        prev_hs    = wr_valid & wr_ready;
        prev_wr    = {wr_addr, wr_data};
        prev_busy  = tx_busy;
        prev_send  = tx_send;
    end

    function automatic logic [7:0] bump(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Reference frame rule: checksum is the 8-bit sum of ADDR, DHI and DLO.
    task automatic expect_frame(input logic [7:0] a, input logic [7:0] dh,
                                input logic [7:0] dl, input logic [7:0] cs);
        logic [7:0] s;
        s = 8'((int'(a) + int'(dh) + int'(dl)) % 256);
        if (cs == s) begin
            exp_wr.push_back({a, dh, dl});
            exp_tx.push_back(ACK);
        end else begin
            exp_tx.push_back(NAK);
            model_err = bump(model_err);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data   = b;
        rx_toggle = ~rx_toggle;
    endtask

    task automatic send_after(input int gap, input logic [7:0] b);
        repeat (gap - 1) @(negedge clk);
        send_byte(b);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] cs);
        send_byte(SYNC);
        send_byte(a);
        send_byte(dh);
        send_byte(dl);
        send_byte(cs);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_tx.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_wr.size() != 0 || exp_tx.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d writes and %0d responses pending, required 0",
                     name, exp_wr.size(), exp_tx.size());
            exp_wr.delete();
            exp_tx.delete();
        end
        @(negedge clk);
        #2;
    endtask

    task automatic check_err(input string name);
        vectors++;
        if (err_count !== model_err) begin
            miscompares++;
            $display("FAIL %s_err: got %0d, required %0d", name, err_count, model_err);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #2;
        vectors++;
        if ({wr_addr, wr_data, wr_valid, tx_data, tx_send, err_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got addr=%h data=%h valid=%b tx=%h send=%b err=%h, required all 0",
                     wr_addr, wr_data, wr_valid, tx_data, tx_send, err_count);
        end
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        // A stray strobe on the held-high toggle would open a frame and time out.
        repeat (T + 10) @(negedge clk);
        #2;
        check_err("arming");
        send_byte(8'h00);
        repeat (4) @(negedge clk);
        #2;
        check_err("idle_noise");
    endtask

    task automatic test_basic();
        wr_ready = 1'b1;
        tx_busy  = 1'b0;
        expect_frame(8'h10, 8'h12, 8'h34, 8'h56);
        send_frame(8'h10, 8'h12, 8'h34, 8'h56);
        @(negedge clk);
        #2;
        vectors++;
        if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h10, 16'h1234}) begin
            miscompares++;
            $display("FAIL basic_write: got valid=%b addr=%h data=%h, required 1 10 1234",
                     wr_valid, wr_addr, wr_data);
        end
        wait_idle("basic");
        vectors++;
        if (tx_data !== ACK) begin
            miscompares++;
            $display("FAIL basic_ack: got %h, required %h", tx_data, ACK);
        end
        check_err("basic");
    endtask

    task automatic test_bad_csum();
        expect_frame(8'h10, 8'h12, 8'h34, 8'h57);
        send_frame(8'h10, 8'h12, 8'h34, 8'h57);
        wait_idle("bad_csum");
        vectors++;
        if (tx_data !== NAK) begin
            miscompares++;
            $display("FAIL bad_csum_nak: got %h, required %h", tx_data, NAK);
        end
        check_err("bad_csum");
    endtask

    task automatic test_timeout();
        send_byte(SYNC);
        send_byte(8'h10);
        repeat (T + 5) @(negedge clk);
        #2;
        model_err = bump(model_err);
        check_err("timeout");
        expect_frame(8'h01, 8'h00, 8'h02, 8'h03);
        send_frame(8'h01, 8'h00, 8'h02, 8'h03);
        wait_idle("after_timeout");
        // Gap of exactly T cycles is still in time.
        expect_frame(8'h10, 8'h12, 8'h34, 8'h56);
        send_byte(SYNC);
        send_after(T, 8'h10);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        wait_idle("gap_limit");
        check_err("gap_limit");
        // One cycle more aborts the frame; the late bytes fall into IDLE.
        send_byte(SYNC);
        send_after(T + 1, 8'h10);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        model_err = bump(model_err);
        repeat (8) @(negedge clk);
        #2;
        check_err("gap_over");
    endtask

    task automatic test_backpressure();
        wr_ready = 1'b0;
        tx_busy  = 1'b1;
        expect_frame(8'hFF, 8'hFF, 8'hFF, 8'hFD);
        send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFD);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            vectors++;
            if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'hFF, 16'hFFFF}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got valid=%b addr=%h data=%h, required 1 ff ffff",
                         i, wr_valid, wr_addr, wr_data);
            end
        end
        @(negedge clk);
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            vectors++;
            if (tx_send !== 1'b0 || wr_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_hold[%0d]: got send=%b valid=%b, required 0 0", i, tx_send, wr_valid);
            end
        end
        @(negedge clk);
        tx_busy = 1'b0;
        wait_idle("backpressure");
        check_err("backpressure");
    endtask

    task automatic test_overrun();
        wr_ready = 1'b0;
        tx_busy  = 1'b0;
        expect_frame(8'h20, 8'h00, 8'h01, 8'h21);
        send_frame(8'h20, 8'h00, 8'h01, 8'h21);
        repeat (2) @(negedge clk);
        send_byte(8'h5A);
        model_err = bump(model_err);
        @(negedge clk);
        #2;
        check_err("overrun_write");
        @(negedge clk);
        tx_busy  = 1'b1;
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        send_byte(8'h3C);
        model_err = bump(model_err);
        @(negedge clk);
        #2;
        check_err("overrun_resp");
        @(negedge clk);
        tx_busy = 1'b0;
        wait_idle("overrun");
        expect_frame(8'h40, 8'h01, 8'h02, 8'h43);
        send_frame(8'h40, 8'h01, 8'h02, 8'h43);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            send_byte(8'(i));
            model_err = bump(model_err);
        end
        @(negedge clk);
        #2;
        check_err("saturate");
        @(negedge clk);
        wr_ready = 1'b1;
        wait_idle("saturate");
    endtask

    task automatic test_reset_mid();
        wr_ready = 1'b1;
        send_byte(SYNC);
        send_byte(8'h10);
        send_byte(8'h12);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        model_err = 8'd0;
        vectors++;
        if ({wr_addr, wr_data, wr_valid, tx_data, tx_send, err_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_dlo: got addr=%h data=%h valid=%b tx=%h send=%b err=%h, required all 0",
                     wr_addr, wr_data, wr_valid, tx_data, tx_send, err_count);
        end
        @(negedge clk);
        reset    = 1'b0;
        wr_ready = 1'b0;
        send_frame(8'h30, 8'h00, 8'h00, 8'h30);
        @(negedge clk);
        #2;
        vectors++;
        if (wr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_valid: got %b, required 1", wr_valid);
        end
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (wr_valid !== 1'b0 || tx_send !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_write: got valid=%b send=%b, required 0 0", wr_valid, tx_send);
        end
        @(negedge clk);
        reset    = 1'b0;
        wr_ready = 1'b1;
        expect_frame(8'h10, 8'h12, 8'h34, 8'h56);
        send_frame(8'h10, 8'h12, 8'h34, 8'h56);
        wait_idle("reset_recover");
        check_err("reset_recover");
    endtask

    task automatic test_random();
        int         kind;
        int         noise;
        int         keep;
        logic [7:0] b;
        logic [7:0] a;
        logic [7:0] dh;
        logic [7:0] dl;
        logic [7:0] cs;
        rand_hs = 1'b1;
        for (int f = 0; f < 30; f++) begin
            kind  = $urandom_range(0, 9);
            noise = $urandom_range(0, 2);
            for (int n = 0; n < noise; n++) begin
                do b = 8'($urandom_range(0, 255)); while (b == SYNC);
                send_after($urandom_range(1, 4), b);
            end
            a  = 8'($urandom_range(0, 255));
            dh = 8'($urandom_range(0, 255));
            dl = 8'($urandom_range(0, 255));
            cs = 8'((int'(a) + int'(dh) + int'(dl)) % 256);
            if (kind < 2) begin
                keep = $urandom_range(0, 3);
                send_after($urandom_range(1, 4), SYNC);
                if (keep > 0) send_after($urandom_range(1, 4), a);
                if (keep > 1) send_after($urandom_range(1, 4), dh);
                if (keep > 2) send_after($urandom_range(1, 4), dl);
                repeat (T + 5) @(negedge clk);
                #2;
                model_err = bump(model_err);
            end else begin
                if (kind < 4) cs = cs + 8'($urandom_range(1, 255));
                expect_frame(a, dh, dl, cs);
                send_after($urandom_range(1, 4), SYNC);
                send_after($urandom_range(1, 4), a);
                send_after($urandom_range(1, 4), dh);
                send_after($urandom_range(1, 4), dl);
                send_after($urandom_range(1, 4), cs);
                wait_idle("random");
            end
            check_err("random");
        end
        rand_hs = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_timeout();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_random();
        repeat (4) @(negedge clk);
        vectors++;
        if (exp_wr.size() != 0 || exp_tx.size() != 0) begin
            miscompares++;
            $display("FAIL final_queues: got %0d writes and %0d responses pending, required 0",
                     exp_wr.size(), exp_tx.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion after 500000 time units, required completion");
        $fatal(1, "bench did not complete");
    end

endmodule
